datamem_arbiter: RTL and testbench

//  Shares the single-port data memory (datamem) between the CPU MEM stage (port C) and a

---
 rtl/datamem_arbiter.sv | 149 ++++++++++++++
 tb/tb_datamem_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/datamem_arbiter.sv
// Single-port data memory arbiter: CPU (C) has priority, D is protected by a wait
// counter and may hold a locked burst for loading memory; reads return one cycle later.
module datamem_arbiter #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              cpu_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned BURST_W = $clog2(BURST_MAX);
  localparam logic [WAIT_W-1:0]  WAIT_SAT   = WAIT_W'(MAX_WAIT);
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX - 1);

  typedef enum logic {
    ST_ARB,
    ST_DBG_BURST
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [BURST_W-1:0]  r_burst_cnt, w_burst_nxt;
  logic                r_pend_c, w_pend_nxt;
  logic                w_c_gnt, w_d_gnt;

  logic                r_c_rvalid, r_d_rvalid;
  logic [DATA_W-1:0]   r_c_rdata, r_d_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ARB;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_pend_c    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_pend_c    <= w_pend_nxt;
    end
  end

  always_comb begin
    w_c_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_burst_nxt = r_burst_cnt;
    w_pend_nxt  = r_pend_c;
    case (r_state)
      ST_ARB: begin
        if (d_req && (!c_req || r_wait_cnt == WAIT_SAT)) w_d_gnt = 1'b1;
        else if (c_req)                                  w_c_gnt = 1'b1;

        if (!d_req || w_d_gnt)         w_wait_nxt = '0;
        else if (r_wait_cnt != WAIT_SAT) w_wait_nxt = r_wait_cnt + WAIT_W'(1);

        if (w_c_gnt || !c_req) w_pend_nxt = 1'b0;

        // A forced exit leaves pend_c set so D cannot immediately re-lock the memory.
        if (w_d_gnt && d_lock && !r_pend_c) begin
          w_state_nxt = ST_DBG_BURST;
          w_burst_nxt = BURST_W'(1);
        end
      end
      ST_DBG_BURST: begin
        w_d_gnt = d_req;
        if (w_d_gnt) w_burst_nxt = r_burst_cnt + BURST_W'(1);

        if (w_d_gnt && r_burst_cnt == BURST_LAST) begin
          w_state_nxt = ST_ARB;
          w_wait_nxt  = '0;
          w_burst_nxt = '0;
          w_pend_nxt  = 1'b1;
        end else if (!d_lock) begin
          w_state_nxt = ST_ARB;
          w_wait_nxt  = '0;
          w_burst_nxt = '0;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (w_c_gnt) begin
      mem_address      = c_addr;
      mem_write_data   = c_wdata;
      mem_write_enable = c_we;
      mem_read_enable  = ~c_we;
    end else if (w_d_gnt) begin
      mem_address      = d_addr;
      mem_write_data   = d_wdata;
      mem_write_enable = d_we;
      mem_read_enable  = ~d_we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_c_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_c_rvalid <= w_c_gnt & ~c_we;
      r_d_rvalid <= w_d_gnt & ~d_we;
      if (w_c_gnt && !c_we) r_c_rdata <= mem_read_data;
      if (w_d_gnt && !d_we) r_d_rdata <= mem_read_data;
    end
  end

  assign c_gnt     = w_c_gnt;
  assign d_gnt     = w_d_gnt;
  assign cpu_stall = c_req & ~w_c_gnt;
  assign c_rvalid  = r_c_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign c_rdata   = r_c_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: vector table plus burst and reset sequences.
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, d_req, d_we, d_lock;
  logic [63:0] c_addr, c_wdata, d_addr, d_wdata, mem_read_data;
  logic        c_gnt, c_rvalid, cpu_stall, d_gnt, d_rvalid;
  logic [63:0] c_rdata, d_rdata, mem_address, mem_write_data;
  logic        mem_write_enable, mem_read_enable;

  int checks = 0;
  int errors = 0;

  datamem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4), .BURST_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c_req, c_we;
    logic [63:0] c_addr, c_wdata;
    logic d_req, d_we, d_lock;
    logic [63:0] d_addr, d_wdata, rd;
    logic e_cg, e_dg, e_st, e_we, e_re;
    logic [63:0] e_addr, e_wdata;
    logic e_crv;
    logic [63:0] e_crd;
    logic e_drv;
    logic [63:0] e_drd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(
    input logic cr, cw, input logic [63:0] ca, cwd,
    input logic dr, dw, dl, input logic [63:0] da, dwd, rd,
    input logic gc, gd, st, we, re, input logic [63:0] ea, ewd,
    input logic crv, input logic [63:0] crd, input logic drv, input logic [63:0] drd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cwd;
    v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wdata = dwd; v.rd = rd;
    v.e_cg = gc; v.e_dg = gd; v.e_st = st; v.e_we = we; v.e_re = re;
    v.e_addr = ea; v.e_wdata = ewd;
    v.e_crv = crv; v.e_crd = crd; v.e_drv = drv; v.e_drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
    d_req = v.d_req; d_we = v.d_we; d_lock = v.d_lock; d_addr = v.d_addr;
    d_wdata = v.d_wdata; mem_read_data = v.rd;
  endtask

  task automatic run(input vec_t v, input string tag);
    drive(v);
    #2;
    chk({tag, ".c_gnt"}, c_gnt, v.e_cg);
    chk({tag, ".d_gnt"}, d_gnt, v.e_dg);
    chk({tag, ".stall"}, cpu_stall, v.e_st);
    chk({tag, ".mem_we"}, mem_write_enable, v.e_we);
    chk({tag, ".mem_re"}, mem_read_enable, v.e_re);
    chk({tag, ".mem_addr"}, mem_address, v.e_addr);
    chk({tag, ".mem_wdata"}, mem_write_data, v.e_wdata);
    @(posedge clk);
    #1;
    chk({tag, ".c_rvalid"}, c_rvalid, v.e_crv);
    chk({tag, ".c_rdata"}, c_rdata, v.e_crd);
    chk({tag, ".d_rvalid"}, d_rvalid, v.e_drv);
    chk({tag, ".d_rdata"}, d_rdata, v.e_drd);
  endtask

  vec_t idle;

  initial begin
    idle = mkv(0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,64'hA8, 0,64'hA9);

    // C-only read, idle hold, back-to-back C/D reads, C write
    tbl.push_back(mkv(1,0,64'h10,0, 0,0,0,0,0,64'hABCD, 1,0,0,0,1,64'h10,0, 1,64'hABCD,0,0));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,64'h5555, 0,0,0,0,0,0,0, 0,64'hABCD,0,0));
    tbl.push_back(mkv(1,0,64'h20,0, 0,0,0,0,0,64'h11, 1,0,0,0,1,64'h20,0, 1,64'h11,0,0));
    tbl.push_back(mkv(0,0,0,0, 1,0,0,64'h28,0,64'h22, 0,1,0,0,1,64'h28,0, 0,64'h11,1,64'h22));
    tbl.push_back(mkv(0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,64'h11,0,64'h22));
    tbl.push_back(mkv(1,1,64'h30,64'h77, 0,0,0,0,0,64'hEE, 1,0,0,1,0,64'h30,64'h77, 0,64'h11,0,64'h22));
    // Contention: CCCCD CCCCD
    for (int j = 0; j < 10; j++) begin
      logic [63:0] rd, crd, drd;
      rd  = 64'hA0 + 64'(j);
      crd = (j < 4) ? rd : (j < 5) ? 64'hA3 : (j < 9) ? rd : 64'hA8;
      drd = (j < 4) ? 64'h22 : (j < 9) ? 64'hA4 : 64'hA9;
      if (j == 4 || j == 9)
        tbl.push_back(mkv(1,0,64'h40,64'hC0, 1,0,0,64'h80,64'hD0,rd,
                          0,1,1,0,1,64'h80,64'hD0, 0,crd,1,drd));
      else
        tbl.push_back(mkv(1,0,64'h40,64'hC0, 1,0,0,64'h80,64'hD0,rd,
                          1,0,0,0,1,64'h40,64'hC0, 1,crd,0,drd));
    end

    reset = 1'b1;
    drive(idle);
    #3;
    chk("rst.c_rvalid", c_rvalid, 0);
    chk("rst.d_rvalid", d_rvalid, 0);
    chk("rst.c_rdata", c_rdata, 0);
    chk("rst.d_rdata", d_rdata, 0);
    chk("rst.mem_addr", mem_address, 0);
    chk("rst.gnt", {c_gnt, d_gnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

    // Locked burst, 16 D writes then forced exit; C wins despite d_req/d_lock
    run(mkv(0,1,64'h300,64'hC3, 1,1,1,0,64'h1000,0, 0,1,0,1,0,0,64'h1000, 0,64'hA8,0,64'hA9), "b0");
    for (int k = 1; k < 16; k++)
      run(mkv(1,1,64'h300,64'hC3, 1,1,1,64'(8*k),64'h1000+64'(k),0,
              0,1,1,1,0,64'(8*k),64'h1000+64'(k), 0,64'hA8,0,64'hA9), $sformatf("b%0d", k));
    run(mkv(1,1,64'h300,64'hC3, 1,1,1,64'h80,64'h1010,0,
            1,0,0,1,0,64'h300,64'hC3, 0,64'hA8,0,64'hA9), "b_exit");
    run(idle, "b_idle");

    // Burst release: gap keeps the burst open, 4th grant on the ~d_lock cycle
    run(mkv(0,1,64'h300,64'hC3, 1,1,1,64'h400,64'h2000,0, 0,1,0,1,0,64'h400,64'h2000, 0,64'hA8,0,64'hA9), "r0");
    run(mkv(1,1,64'h300,64'hC3, 1,1,1,64'h408,64'h2001,0, 0,1,1,1,0,64'h408,64'h2001, 0,64'hA8,0,64'hA9), "r1");
    run(mkv(1,1,64'h300,64'hC3, 0,1,1,64'h40C,64'h2009,0, 0,0,1,0,0,0,0, 0,64'hA8,0,64'hA9), "r_gap");
    run(mkv(1,1,64'h300,64'hC3, 1,1,1,64'h410,64'h2002,0, 0,1,1,1,0,64'h410,64'h2002, 0,64'hA8,0,64'hA9), "r2");
    run(mkv(1,1,64'h300,64'hC3, 1,1,0,64'h418,64'h2003,0, 0,1,1,1,0,64'h418,64'h2003, 0,64'hA8,0,64'hA9), "r3");
    run(mkv(1,1,64'h300,64'hC3, 1,1,0,64'h420,64'h2004,0, 1,0,0,1,0,64'h300,64'hC3, 0,64'hA8,0,64'hA9), "r_arb");
    run(idle, "r_idle");

    // Async reset mid-burst with a D read in flight
    run(mkv(0,0,0,0, 1,0,1,64'h500,0,64'h44, 0,1,0,0,1,64'h500,0, 0,64'hA8,1,64'h44), "x0");
    drive(mkv(1,0,64'h600,0, 1,0,1,64'h508,0,64'h33, 0,0,0,0,0,0,0, 0,0,0,0));
    #2;
    chk("x1.d_gnt", d_gnt, 1);
    chk("x1.stall", cpu_stall, 1);
    reset = 1'b1;
    #1;
    chk("x_rst.d_rvalid", d_rvalid, 0);
    chk("x_rst.d_rdata", d_rdata, 0);
    chk("x_rst.c_rdata", c_rdata, 0);
    chk("x_rst.c_gnt", c_gnt, 1);
    chk("x_rst.d_gnt", d_gnt, 0);
    @(posedge clk);
    #1;
    chk("x_hold.d_rvalid", d_rvalid, 0);
    chk("x_hold.c_rvalid", c_rvalid, 0);
    reset = 1'b0;
    #2;
    chk("x_rel.c_gnt", c_gnt, 1);
    chk("x_rel.d_gnt", d_gnt, 0);
    chk("x_rel.mem_addr", mem_address, 64'h600);
    @(posedge clk);
    #1;
    chk("x_rel.c_rvalid", c_rvalid, 1);
    chk("x_rel.c_rdata", c_rdata, 64'h33);
    chk("x_rel.d_rvalid", d_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
